// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter/router.
// Holds the FSM state encoding, field widths, the broadcast id and a
// saturating increment used by the drop counter.
package bus_arb_pkg;

  // Arbitration sequence: decide in IDLE, pop in POP, deliver in PUSH.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  // Destination field width at the top of every packet.
  localparam int unsigned ID_W     = 8;
  // Destination value reserved for broadcast when that feature is built in.
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  // Width of the dropped-packet counter.
  localparam int unsigned DROP_W   = 16;
  // Width of agent indices (grant and last-served); covers up to 16 agents.
  localparam int unsigned GNT_W    = 4;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin pick: masked priority encoder over the pending vector.
// Latency: purely combinational, result valid in the same cycle.
// Backpressure: none; the caller decides when to sample the result.
module bus_rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     pndng,
  input  logic [GNT_W-1:0] last,
  output logic [GNT_W-1:0] gnt,
  output logic             valid
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;

  // Agents strictly above the last-served index get first chance; when
  // last is the top agent the mask is empty and the search wraps to 0.
  always_comb begin
    mask = '0;
    for (int j = 0; j < N; j++) begin
      mask[j] = (GNT_W'(j) > last);
    end
  end

  assign masked = pndng & mask;

  // Lowest set bit of the unmasked vector is the wrap-around fallback;
  // the lowest set bit of the masked vector, if any, overrides it.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (pndng[j]) begin
        gnt   = GNT_W'(j);
        valid = 1'b1;
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (masked[j]) begin
        gnt = GNT_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/router: pops one agent FIFO, forwards the packet to its destination FIFO.
// Latency: pndng seen in IDLE cycle N -> pop in N+1 -> push in N+2; one packet per 3 cycles.
// Backpressure: none downstream; upstream held via pndng. Optional broadcast: BUS_ARB_BCAST_EN.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned drvrs   = 4,
  parameter int unsigned pckg_sz = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [drvrs*pckg_sz-1:0]   D_push,
  output logic                       busy,
  output logic [GNT_W-1:0]           gnt_id,
  output logic [DROP_W-1:0]          drop_cnt
);

`ifdef BUS_ARB_BCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  // Registered state.
  state_e              state_q, state_d;
  logic [GNT_W-1:0]    gnt_q, gnt_d;
  logic [GNT_W-1:0]    last_q, last_d;
  logic [drvrs-1:0]    pop_q, pop_d;
  logic [drvrs-1:0]    push_q, push_d;
  logic [pckg_sz-1:0]  pkt_q, pkt_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                busy_q, busy_d;

  // Combinational helpers.
  logic [GNT_W-1:0]    pick_gnt;
  logic                pick_vld;
  logic [pckg_sz-1:0]  head;
  logic [ID_W-1:0]     dest;
  logic [drvrs-1:0]    fwd_mask;
  logic                fwd_drop;

  bus_rr_pick #(
    .N (drvrs)
  ) u_pick (
    .pndng (pndng),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  // Select the granted agent's head word; it is held stable by the agent
  // from the IDLE decision until the POP edge.
  always_comb begin
    head = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (gnt_q == GNT_W'(i)) begin
        head = D_pop[i*pckg_sz +: pckg_sz];
      end
    end
  end

  assign dest = head[pckg_sz-1 -: ID_W];

  // Destination decode: broadcast goes to everyone but the source, a valid
  // index goes to that agent (source included), anything else is dropped.
  always_comb begin
    fwd_mask = '0;
    fwd_drop = 1'b0;
    if (BCAST_EN && (dest == BCAST_ID)) begin
      for (int j = 0; j < drvrs; j++) begin
        fwd_mask[j] = (GNT_W'(j) != gnt_q);
      end
    end else if (dest < ID_W'(drvrs)) begin
      for (int j = 0; j < drvrs; j++) begin
        fwd_mask[j] = (dest == ID_W'(j));
      end
    end else begin
      fwd_drop = 1'b1;
    end
  end

  // Next-state and registered-output logic. Strobes are computed one state
  // early so pop is high exactly during POP and push exactly during PUSH.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    pop_d   = '0;
    push_d  = '0;
    pkt_d   = pkt_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = POP;
          gnt_d   = pick_gnt;
          for (int j = 0; j < drvrs; j++) begin
            pop_d[j] = (pick_gnt == GNT_W'(j));
          end
        end
      end
      POP: begin
        // The agent retires its head word on this edge, so capture it now.
        pkt_d   = head;
        last_d  = gnt_q;
        push_d  = fwd_mask;
        // Drops are counted on entry to PUSH so drop_cnt is current in the
        // cycle where a push would otherwise have appeared.
        if (fwd_drop) begin
          drop_d = sat_inc(drop_q);
        end
        state_d = PUSH;
      end
      PUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GNT_W'(drvrs - 1);
      pop_q   <= '0;
      push_q  <= '0;
      pkt_q   <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = {drvrs{pkt_q}};
  assign busy     = busy_q;
  assign gnt_id   = gnt_q;
  assign drop_cnt = drop_q;

  // Strobe sanity: at most one pop at a time, and strobes only in their state.
  a_pop_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(pop_q));
  a_pop_state  : assert property (@(posedge clk) disable iff (reset) (pop_q != '0) |-> (state_q == POP));
  a_push_state : assert property (@(posedge clk) disable iff (reset) (push_q != '0) |-> (state_q == PUSH));

endmodule
